lock_reg_arbiter: RTL and testbench

- Arbitrates write access from NUM_REQ requesters to one lock-protected DATA_W-bit configuration register.
- Owns the register's lock bit, which has a defined reset value, so the register is never writable from an undefined lock state.
- Sits between software/debug requesters and the protected register.
- The lock is sticky until reset.

---
 rtl/lock_reg_arbiter_pkg.sv | 15 +
 rtl/lock_reg_arbiter_rr.sv | 47 ++++
 rtl/lock_reg_arbiter.sv | 107 ++++++++++
 tb/tb_lock_reg_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_reg_arbiter_pkg.sv
// Shared types and default values for the lock-protected register arbiter.
// The optional debug unlock path is enabled by defining LOCK_DEBUG_UNLOCK_EN.
package lock_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  localparam int                        DEFAULT_DATA_W     = 6;
  localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_RST_VAL    = '0;
  localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_UNLOCK_KEY = 6'h2A;

endpackage

// File: rtl/lock_reg_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from an internal pointer that
// moves past a requester only when that requester's write completes.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   adv_idx;
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] first;

  // Rotate so the pointer position is bit 0, isolate the lowest set bit,
  // then rotate back to the original requester numbering.
  always_comb begin
    rot   = NUM_REQ'({req, req} >> ptr);
    first = rot & (~rot + NUM_REQ'(1));
    grant = NUM_REQ'(({first, first} << ptr) >> NUM_REQ);
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    adv_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (advance[k]) adv_idx = PTR_W'(k);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (|advance) begin
      ptr <= (adv_idx == PTR_W'(NUM_REQ - 1)) ? '0 : adv_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/lock_reg_arbiter.sv
// Write arbiter for one lock-protected register with a sticky lock bit.
// Define LOCK_DEBUG_UNLOCK_EN to add the dbg_unlock/dbg_key unlock path.
module lock_reg_arbiter
  import lock_reg_pkg::*;
#(
  parameter int                NUM_REQ    = 4,
  parameter int                DATA_W     = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL    = DATA_W'(DEFAULT_RST_VAL)
`ifdef LOCK_DEBUG_UNLOCK_EN
  ,
  parameter logic [DATA_W-1:0] UNLOCK_KEY = DATA_W'(DEFAULT_UNLOCK_KEY)
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  input  logic                      lock_set,
`ifdef LOCK_DEBUG_UNLOCK_EN
  input  logic                      dbg_unlock,
  input  logic [DATA_W-1:0]         dbg_key,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        deny,
  output logic [DATA_W-1:0]         data_out,
  output logic                      lock_value
);

  lock_state_e        state;
  logic [NUM_REQ-1:0] arb_grant;
  logic [NUM_REQ-1:0] write_done;
  logic [DATA_W-1:0]  sel_data;
  logic               grant_held;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) sel_data = sel_data | wr_data[k*DATA_W +: DATA_W];
    end
  end

  assign grant_held = |(gnt & req);
  // The pointer only moves on a write that actually lands (not abort/deny).
  assign write_done = (state == GRANT && !lock_set && grant_held) ? gnt : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (write_done),
    .grant   (arb_grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      ack        <= '0;
      deny       <= '0;
      data_out   <= RST_VAL;
      lock_value <= 1'b0;
    end else begin
      gnt  <= '0;
      ack  <= '0;
      deny <= '0;
      unique case (state)
        IDLE: begin
          if (lock_set) begin
            state      <= LOCKED;
            lock_value <= 1'b1;
          end else if (|req) begin
            gnt   <= arb_grant;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (lock_set) begin
            deny       <= gnt;
            state      <= LOCKED;
            lock_value <= 1'b1;
          end else if (grant_held) begin
            data_out <= sel_data;
            ack      <= gnt;
            state    <= IDLE;
          end else begin
            state <= IDLE;
          end
        end
        LOCKED: begin
`ifdef LOCK_DEBUG_UNLOCK_EN
          if (dbg_unlock && dbg_key == UNLOCK_KEY) begin
            state      <= IDLE;
            lock_value <= 1'b0;
          end else begin
            deny <= req;
          end
`else
          deny <= req;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_reg_arbiter.sv
// Directed bench for lock_reg_arbiter: a transaction-level model checked every
// cycle on the falling edge, plus hand-computed literal checks per scenario.
module tb_lock_reg_arbiter;

  localparam int N = 4;
  localparam int W = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wr_data = '0;
  logic           lock_set = 1'b0;
`ifdef LOCK_DEBUG_UNLOCK_EN
  logic           dbg_unlock = 1'b0;
  logic [W-1:0]   dbg_key = '0;
`endif
  logic [N-1:0]   gnt, ack, deny;
  logic [W-1:0]   data_out;
  logic           lock_value;

  int vectors = 0;
  int miscompares = 0;

  lock_reg_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .wr_data    (wr_data),
    .lock_set   (lock_set),
`ifdef LOCK_DEBUG_UNLOCK_EN
    .dbg_unlock (dbg_unlock),
    .dbg_key    (dbg_key),
`endif
    .gnt        (gnt),
    .ack        (ack),
    .deny       (deny),
    .data_out   (data_out),
    .lock_value (lock_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction model: who owns the current grant (-1 = none), whether the
  // register is locked, and whose turn it is next.
  int           m_owner;
  int           m_ptr;
  bit           m_locked;
  logic [W-1:0] m_data;
  logic [N-1:0] e_gnt, e_ack, e_deny;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_locked = 0; m_data = '0;
      e_gnt = '0; e_ack = '0; e_deny = '0;
    end else begin
      e_gnt = '0; e_ack = '0; e_deny = '0;
      if (m_locked) begin
`ifdef LOCK_DEBUG_UNLOCK_EN
        if (dbg_unlock && dbg_key == 6'h2A) m_locked = 0;
        else e_deny = req;
`else
        e_deny = req;
`endif
      end else if (m_owner < 0) begin
        if (lock_set) m_locked = 1;
        else begin
          for (int k = 0; k < N; k++)
            if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
          if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        end
      end else begin
        if (lock_set) begin
          e_deny[m_owner] = 1'b1;
          m_locked = 1;
        end else if (req[m_owner]) begin
          m_data = wr_data[m_owner*W +: W];
          e_ack[m_owner] = 1'b1;
          m_ptr = (m_owner + 1) % N;
        end
        m_owner = -1;
      end
    end
  end

  always @(negedge clk) begin
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("ack", 32'(ack), 32'(e_ack));
    check("deny", 32'(deny), 32'(e_deny));
    check("data_out", 32'(data_out), 32'(m_data));
    check("lock_value", 32'(lock_value), 32'(m_locked));
  end

  // Advance n rising edges and land 2 time units after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    // 1: reset/idle, including an asynchronous reset between edges
    check("rst_data", 32'(data_out), 32'h00);
    check("rst_lock", 32'(lock_value), 32'h0);
    check("rst_pulses", 32'({gnt, ack, deny}), 32'h0);
    #1 reset = 1'b1;
    #1 check("async_rst_data", 32'(data_out), 32'h00);
    reset = 1'b0;
    tick(1);

    // 2: single write from requester 1
    req = 4'b0010;
    wr_data[1*W +: W] = 6'h15;
    tick(1);
    check("w1_gnt", 32'(gnt), 32'b0010);
    check("w1_ack_early", 32'(ack), 32'h0);
    tick(1);
    check("w1_ack", 32'(ack), 32'b0010);
    check("w1_data", 32'(data_out), 32'h15);
    req = '0;
    tick(1);
    check("w1_ack_pulse", 32'(ack), 32'h0);

    // 3: round robin from pointer 0 with wrap back to 0 after 3
    pulse_reset();
    tick(1);
    wr_data = '0;
    wr_data[0*W +: W] = 6'h01;
    wr_data[1*W +: W] = 6'h02;
    wr_data[3*W +: W] = 6'h03;
    req = 4'b1011;
    tick(1); check("rr_gnt0", 32'(gnt), 32'b0001);
    tick(1); check("rr_ack0", 32'(ack), 32'b0001);
    req = 4'b1010;
    tick(1); check("rr_gnt1", 32'(gnt), 32'b0010);
    tick(1); check("rr_data1", 32'(data_out), 32'h02);
    req = 4'b1001;
    tick(1); check("rr_gnt3", 32'(gnt), 32'b1000);
    tick(1); check("rr_data3", 32'(data_out), 32'h03);
    tick(1); check("rr_gnt0_wrap", 32'(gnt), 32'b0001);
    tick(1); check("rr_data0", 32'(data_out), 32'h01);
    req = '0;
    tick(1);

    // 4: lock arriving during GRANT, then denial of a later request
    req = 4'b0100;
    wr_data[2*W +: W] = 6'h3F;
    tick(1); check("lk_gnt2", 32'(gnt), 32'b0100);
    lock_set = 1'b1;
    tick(1);
    check("lk_deny2", 32'(deny), 32'b0100);
    check("lk_data_kept", 32'(data_out), 32'h01);
    check("lk_lock", 32'(lock_value), 32'h1);
    lock_set = 1'b0;
    req = '0;
    tick(1); check("lk_deny_clear", 32'(deny), 32'h0);
    req = 4'b0001;
    tick(1); check("lk_deny0", 32'(deny), 32'b0001);
    tick(1);
    check("lk_deny0_held", 32'(deny), 32'b0001);
    check("lk_no_gnt", 32'(gnt), 32'h0);
    req = '0;
    tick(1);

    // 5: lock beats a request in the same IDLE cycle; reset clears the lock
    pulse_reset();
    tick(1);
    lock_set = 1'b1;
    req = 4'b0001;
    tick(1);
    check("pri_lock", 32'(lock_value), 32'h1);
    check("pri_no_gnt", 32'(gnt), 32'h0);
    lock_set = 1'b0;
    tick(1); check("pri_deny0", 32'(deny), 32'b0001);
    #1 reset = 1'b1;
    #1 check("pri_rst_lock", 32'(lock_value), 32'h0);
    check("pri_rst_data", 32'(data_out), 32'h00);
    reset = 1'b0;
    req = '0;
    tick(1);

    // 6a: early abort does not write and does not move the pointer
    req = 4'b0010;
    wr_data[1*W +: W] = 6'h15;
    tick(2); check("ab_pre_data", 32'(data_out), 32'h15);
    req = 4'b0100;
    tick(1); check("ab_gnt2", 32'(gnt), 32'b0100);
    req = '0;
    tick(1);
    check("ab_no_ack", 32'(ack), 32'h0);
    check("ab_data_kept", 32'(data_out), 32'h15);
    req = 4'b1100;
    tick(1); check("ab_ptr_kept", 32'(gnt), 32'b0100);
    tick(1); check("ab_data3f", 32'(data_out), 32'h3F);
    req = '0;
    tick(1);

`ifdef LOCK_DEBUG_UNLOCK_EN
    // 6b: wrong key keeps the lock, right key releases it, data survives
    lock_set = 1'b1;
    tick(1);
    lock_set = 1'b0;
    dbg_unlock = 1'b1;
    dbg_key = 6'h2B;
    req = 4'b0001;
    tick(1);
    check("dbg_wrong_lock", 32'(lock_value), 32'h1);
    check("dbg_wrong_deny", 32'(deny), 32'b0001);
    dbg_key = 6'h2A;
    req = '0;
    tick(1);
    check("dbg_unlock", 32'(lock_value), 32'h0);
    check("dbg_data_kept", 32'(data_out), 32'h3F);
    dbg_unlock = 1'b0;
    tick(1);
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
